cart_debug_dma: RTL and testbench
=================================

# cart_debug_dma

Sequences the USB debug DMA transfer: on a start strobe from the cart control register block it pulls bytes from the USB receive FIFO, packs them into 16-bit words and writes them through the SDRAM memory-bus request/ack port at a programmed bank and address. It sits between the cart control registers (start/stop/bank/address/length, busy/done back) and the SDRAM arbiter's debug requester port. Transfers are byte-counted; odd lengths are zero-padded in the final word.

## Interface
- `LENGTH_BITS`, 20: width of the byte-length counter.
- `i_clk`  in  1  system clock.
- `i_reset_n`  in  1  synchronous, active-low reset.
- `i_start`  in  1  one-cycle strobe; latches bank, address and length. Ignored while `o_busy`=1.
- `i_stop`  in  1  one-cycle abort strobe.
- `i_bank`  in  4  target memory bank.
- `i_address`  in  24  start address, 16-bit-word granular.
- `i_length`  in  LENGTH_BITS  transfer length in bytes.
- `o_busy`  out  1  transfer in progress.
- `o_done`  out  1  one-cycle pulse on normal completion.
- `i_rx_empty`  in  1  USB RX FIFO empty.
- `o_rx_read`  out  1  FIFO pop strobe; data valid the following cycle.
- `i_rx_data`  in  8  FIFO read data.
- `o_mem_request`  out  1  memory write request.
- `i_mem_ack`  in  1  request accepted.
- `o_mem_bank`  out  4  bank of current write.
- `o_mem_address`  out  24  word address of current write.
- `o_mem_data`  out  16  write data.

## Operation
- States: IDLE, READ_HI, LATCH_HI, READ_LO, LATCH_LO, WRITE, DONE.
- IDLE: on `i_start` latch bank, address and length into `r_remaining`. If length=0, go to DONE; otherwise go to READ_HI.
- READ_HI: assert `o_rx_read` only when `i_rx_empty`=0, then go to LATCH_HI. Stall while the FIFO is empty.
- LATCH_HI: capture `i_rx_data` into `o_mem_data[15:8]` and decrement `r_remaining`. If `r_remaining` is now 0, set `o_mem_data[7:0]`=8'h00 and go to WRITE; otherwise go to READ_LO.
- READ_LO and LATCH_LO: same as the high-byte pair, capturing into `[7:0]`, then go to WRITE.
- WRITE: hold `o_mem_request`=1 with bank, address and data stable until `i_mem_ack`=1. On ack, increment the address by 1. If `r_remaining`=0 go to DONE, else go to READ_HI.
- DONE: pulse `o_done` for one cycle, then go to IDLE.
- Address arithmetic is 24-bit unsigned: it wraps from FF_FFFF to 00_0000 and the bank never changes.
- Abort (`i_stop`):
  - In READ or LATCH states: go to IDLE on the next cycle. A byte already popped is discarded.
  - In WRITE: finish the outstanding handshake (wait for ack), then go to IDLE.
  - An abort never produces `o_done`.
- `i_stop` and `i_start` together in IDLE: the start wins.
- `i_stop` in IDLE or DONE: no effect.

## Timing
- Reset values: `o_busy`=0, `o_done`=0, `o_rx_read`=0, `o_mem_request`=0, `o_mem_bank`=0, `o_mem_address`=0, `o_mem_data`=0, state=IDLE. Reset mid-transfer drops `o_mem_request` immediately, with no completion.
- `o_busy` rises the cycle after an accepted `i_start`. It falls in the same cycle `o_done` is high, or on the cycle IDLE is re-entered after an abort.
- `o_rx_read` is a registered one-cycle pulse, never asserted in consecutive cycles.
- `o_mem_request` rises on entry to WRITE and falls the cycle after `i_mem_ack` is sampled high. Ack in the first request cycle is legal.
- Minimum cost per word with no stalls: 5 cycles (4 FIFO + 1 write with immediate ack). Zero-length start gives `o_done` 2 cycles after `i_start`.

## Configuration
- `DEBUG_DMA_BYTE_SWAP_EN` defined: the first byte is packed into `[7:0]` and the second into `[15:8]` (little-endian). The pad byte for odd lengths goes in `[15:8]`.
- Not defined: big-endian packing as described in Operation.

## Test plan
- Start with bank 1, address FC_0000, length 4; FIFO supplies 11,22,33,44 -> two writes: (1, FC_0000, 1122) then (1, FC_0001, 3344); one `o_done` pulse; `o_busy` low afterward.
- Length 3 with bytes AA,BB,CC -> writes AABB at A then CC00 at A+1. With `DEBUG_DMA_BYTE_SWAP_EN`: BBAA then 00CC.
- Length 0 -> no `o_rx_read`, no `o_mem_request`; `o_done` 2 cycles after start.
- Address FF_FFFF, length 4 -> writes at FF_FFFF and 00_0000; `o_mem_bank` unchanged.
- FIFO empty for 10 cycles mid-word, and ack delayed 7 cycles -> no `o_rx_read` while empty; request, address and data held stable until ack; data correct.
- `i_stop` while waiting for ack -> request held until ack, then IDLE, no `o_done`. A later `i_start` runs a full transfer correctly. Asserting `i_reset_n`=0 mid-WRITE -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/cart_debug_dma.sv
// rtl/cart_debug_dma.sv - USB debug DMA: packs RX FIFO bytes into 16-bit SDRAM writes.
// Define DEBUG_DMA_BYTE_SWAP_EN for little-endian packing (first byte in [7:0]).
module cart_debug_dma #(
  parameter int LENGTH_BITS = 20
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_start,
  input  logic                   i_stop,
  input  logic [3:0]             i_bank,
  input  logic [23:0]            i_address,
  input  logic [LENGTH_BITS-1:0] i_length,
  output logic                   o_busy,
  output logic                   o_done,
  input  logic                   i_rx_empty,
  output logic                   o_rx_read,
  input  logic [7:0]             i_rx_data,
  output logic                   o_mem_request,
  input  logic                   i_mem_ack,
  output logic [3:0]             o_mem_bank,
  output logic [23:0]            o_mem_address,
  output logic [15:0]            o_mem_data
);

`ifdef DEBUG_DMA_BYTE_SWAP_EN
  localparam bit BYTE_SWAP = 1'b1;
`else
  localparam bit BYTE_SWAP = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_HI,
    S_LATCH_HI,
    S_READ_LO,
    S_LATCH_LO,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic [LENGTH_BITS-1:0] r_remaining;
  logic                   r_abort;
  logic                   last_byte;

  assign last_byte = (r_remaining == LENGTH_BITS'(1));

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state       <= S_IDLE;
      r_remaining   <= '0;
      r_abort       <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_rx_read     <= 1'b0;
      o_mem_request <= 1'b0;
      o_mem_bank    <= '0;
      o_mem_address <= '0;
      o_mem_data    <= '0;
    end else begin
      o_rx_read <= 1'b0;
      o_done    <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          // start has priority over a coincident stop
          if (i_start) begin
            o_mem_bank    <= i_bank;
            o_mem_address <= i_address;
            r_remaining   <= i_length;
            r_abort       <= 1'b0;
            o_busy        <= 1'b1;
            r_state       <= (i_length == '0) ? S_DONE : S_READ_HI;
          end
        end
        S_READ_HI: begin
          if (i_stop) begin
            o_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (!i_rx_empty) begin
            o_rx_read <= 1'b1;
            r_state   <= S_LATCH_HI;
          end
        end
        S_LATCH_HI: begin
          if (i_stop) begin
            o_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_remaining <= r_remaining - LENGTH_BITS'(1);
            // the other half is zeroed here so an odd tail is already padded
            o_mem_data  <= BYTE_SWAP ? {8'h00, i_rx_data} : {i_rx_data, 8'h00};
            if (last_byte) begin
              o_mem_request <= 1'b1;
              r_state       <= S_WRITE;
            end else begin
              r_state <= S_READ_LO;
            end
          end
        end
        S_READ_LO: begin
          if (i_stop) begin
            o_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (!i_rx_empty) begin
            o_rx_read <= 1'b1;
            r_state   <= S_LATCH_LO;
          end
        end
        S_LATCH_LO: begin
          if (i_stop) begin
            o_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_remaining <= r_remaining - LENGTH_BITS'(1);
            if (BYTE_SWAP) o_mem_data[15:8] <= i_rx_data;
            else           o_mem_data[7:0]  <= i_rx_data;
            o_mem_request <= 1'b1;
            r_state       <= S_WRITE;
          end
        end
        S_WRITE: begin
          // an abort here is remembered until the arbiter accepts the word
          if (i_stop) r_abort <= 1'b1;
          if (i_mem_ack) begin
            o_mem_request <= 1'b0;
            o_mem_address <= o_mem_address + 24'd1;
            if (i_stop || r_abort) begin
              o_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else if (r_remaining == '0) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_READ_HI;
            end
          end
        end
        S_DONE: begin
          o_done  <= 1'b1;
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cart_debug_dma.sv
// tb/tb_cart_debug_dma.sv - randomized bench for cart_debug_dma with FIFO/SDRAM models.
// Honours DEBUG_DMA_BYTE_SWAP_EN for the expected packing.
module tb_cart_debug_dma;

`ifdef DEBUG_DMA_BYTE_SWAP_EN
  localparam bit SWAP = 1'b1;
`else
  localparam bit SWAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, start, stop, rx_empty, mem_ack;
  logic [3:0]  bank;
  logic [23:0] address;
  logic [19:0] length;
  logic [7:0]  rx_data;
  logic        o_busy, o_done, o_rx_read, o_mem_request;
  logic [3:0]  o_mem_bank;
  logic [23:0] o_mem_address;
  logic [15:0] o_mem_data;

  always #5 clk = ~clk;

  cart_debug_dma #(.LENGTH_BITS(20)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_start(start), .i_stop(stop),
    .i_bank(bank), .i_address(address), .i_length(length),
    .o_busy(o_busy), .o_done(o_done),
    .i_rx_empty(rx_empty), .o_rx_read(o_rx_read), .i_rx_data(rx_data),
    .o_mem_request(o_mem_request), .i_mem_ack(mem_ack),
    .o_mem_bank(o_mem_bank), .o_mem_address(o_mem_address), .o_mem_data(o_mem_data)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  fifo_q[$];
  logic [7:0]  tx_bytes[$];
  logic [43:0] got_w[$];
  logic [43:0] exp_w[$];
  int done_cnt = 0;
  int stall_left = 0;
  bit stall_en = 0;
  bit force_stall = 0;
  int ack_mode = 0;
  int ack_wait = -1;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample at the edge, then update the FIFO/arbiter models 1ns later.
  task automatic tick();
    logic rd, req, ack, e, rst_ok;
    logic [43:0] wr;
    rd = o_rx_read; req = o_mem_request; ack = mem_ack; e = rx_empty; rst_ok = reset_n;
    wr = {o_mem_bank, o_mem_address, o_mem_data};
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    if (rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (req && ack && rst_ok) got_w.push_back(wr);
    if (o_done) done_cnt++;
    check("rd_b2b", {1'b0, rd & o_rx_read}, 0);
    if (o_rx_read) check("rd_when_empty", {1'b0, e}, 0);
    if (req && !ack && rst_ok && reset_n)
      check("req_hold", {o_mem_request, o_mem_bank, o_mem_address, o_mem_data}, {1'b1, wr});
    if (stall_left > 0) stall_left--;
    if (force_stall && rd) begin
      stall_left  = 10;
      force_stall = 0;
    end else if (stall_en && !o_rx_read && stall_left == 0 && $urandom_range(0, 7) == 0) begin
      stall_left = $urandom_range(1, 10);
    end
    rx_empty = (fifo_q.size() == 0) || (stall_left > 0);
    rx_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'($urandom);
    if (req && ack) ack_wait = -1;
    if (o_mem_request) begin
      if (ack_wait < 0) ack_wait = (ack_mode < 0) ? $urandom_range(0, 3) : ack_mode;
      else if (ack_wait > 0) ack_wait--;
    end else begin
      ack_wait = -1;
    end
    mem_ack = o_mem_request && (ack_wait == 0);
  endtask

  task automatic build_expected(input logic [3:0] b, input logic [23:0] a, input int len);
    logic [7:0] hi, lo;
    exp_w.delete();
    for (int w = 0; w < (len + 1) / 2; w++) begin
      hi = tx_bytes[2*w];
      lo = (2*w + 1 < len) ? tx_bytes[2*w+1] : 8'h00;
      exp_w.push_back({b, 24'(a + 24'(w)), SWAP ? {lo, hi} : {hi, lo}});
    end
  endtask

  task automatic env_clear();
    fifo_q.delete();
    got_w.delete();
    done_cnt    = 0;
    stall_left  = 0;
    force_stall = 0;
    rx_empty    = 1'b1;
  endtask

  task automatic run_xfer(input logic [3:0] b, input logic [23:0] a, input int len, input bit with_stop);
    build_expected(b, a, len);
    env_clear();
    fifo_q  = tx_bytes;
    bank    = b;
    address = a;
    length  = 20'(len);
    start   = 1'b1;
    stop    = with_stop;
    tick();
    check("busy_rise", {47'b0, o_busy}, 1);
    for (int i = 0; i < 5000 && o_busy; i++) tick();
    check("busy_fall", {47'b0, o_busy}, 0);
    check("done_cnt", 48'(done_cnt), 1);
    check("n_writes", 48'(got_w.size()), 48'(exp_w.size()));
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++)
      check("write", {4'b0, got_w[i]}, {4'b0, exp_w[i]});
    check("fifo_drained", 48'(fifo_q.size()), 0);
  endtask

  task automatic wait_for_request();
    for (int i = 0; i < 500 && !o_mem_request; i++) tick();
    check("req_seen", {47'b0, o_mem_request}, 1);
  endtask

  initial begin
    reset_n = 1'b0; start = 0; stop = 0; bank = 0; address = 0; length = 0;
    rx_empty = 1'b1; rx_data = 0; mem_ack = 0;
    tick(); tick();
    check("rst_outputs", {o_busy, o_done, o_rx_read, o_mem_request, o_mem_bank, o_mem_address, o_mem_data}, 0);
    reset_n = 1'b1;
    tick();

    ack_mode = 0; stall_en = 0;
    tx_bytes = {8'h11, 8'h22, 8'h33, 8'h44};
    run_xfer(4'd1, 24'hFC_0000, 4, 0);
    check("tp1_w0", {4'b0, got_w[0]}, {4'b0, 4'd1, 24'hFC_0000, SWAP ? 16'h2211 : 16'h1122});
    tx_bytes = {8'hAA, 8'hBB, 8'hCC};
    run_xfer(4'd2, 24'h00_1234, 3, 0);
    check("tp2_tail", {32'b0, got_w[got_w.size()-1][15:0]}, SWAP ? 48'h00CC : 48'hCC00);
    tx_bytes = {8'h01, 8'h02, 8'h03, 8'h04};
    run_xfer(4'd5, 24'hFF_FFFF, 4, 0);
    check("wrap_addr", {24'b0, got_w[got_w.size()-1][39:16]}, 0);

    // zero length: done exactly two cycles after start, FIFO untouched
    env_clear();
    fifo_q = {8'h5A};
    rx_empty = 1'b0; rx_data = 8'h5A;
    bank = 4'd3; address = 24'h000123; length = 0; start = 1'b1;
    tick();
    check("z_busy1", {46'b0, o_busy, o_done}, 48'b10);
    tick();
    check("z_done2", {46'b0, o_busy, o_done}, 48'b01);
    tick(); tick();
    check("z_fifo", 48'(fifo_q.size()), 1);
    check("z_writes", 48'(got_w.size()), 0);

    // mid-word 10-cycle FIFO stall plus 7-cycle ack delay
    ack_mode = 7; force_stall = 0;
    tx_bytes = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h77};
    build_expected(4'd9, 24'h00_4000, 5);
    env_clear(); fifo_q = tx_bytes; force_stall = 1;
    bank = 4'd9; address = 24'h00_4000; length = 5; start = 1'b1;
    tick();
    for (int i = 0; i < 5000 && o_busy; i++) tick();
    check("st_done", 48'(done_cnt), 1);
    check("st_n", 48'(got_w.size()), 3);
    for (int i = 0; i < got_w.size() && i < 3; i++) check("st_write", {4'b0, got_w[i]}, {4'b0, exp_w[i]});

    // stop while waiting for ack: finish the handshake, no done
    ack_mode = 3;
    tx_bytes = {8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    build_expected(4'd4, 24'h00_0800, 6);
    env_clear(); fifo_q = tx_bytes;
    bank = 4'd4; address = 24'h00_0800; length = 6; start = 1'b1;
    tick();
    wait_for_request();
    stop = 1'b1;
    for (int i = 0; i < 200 && o_busy; i++) tick();
    tick(); tick();
    check("abw_busy", {46'b0, o_busy, o_mem_request}, 0);
    check("abw_done", 48'(done_cnt), 0);
    check("abw_n", 48'(got_w.size()), 1);
    check("abw_w0", {4'b0, got_w[0]}, {4'b0, exp_w[0]});
    tx_bytes = {8'h5C, 8'hC5};
    run_xfer(4'd4, 24'h00_0900, 2, 0);

    // stop in LATCH_HI: popped byte dropped, back to idle next cycle
    env_clear();
    fifo_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    bank = 4'd6; address = 24'h00_0010; length = 8; start = 1'b1;
    tick();
    for (int i = 0; i < 50 && !o_rx_read; i++) tick();
    stop = 1'b1;
    tick();
    check("abl_busy", {47'b0, o_busy}, 0);
    check("abl_fifo", 48'(fifo_q.size()), 7);
    tick(); tick(); tick();
    check("abl_quiet", {46'b0, o_rx_read, o_mem_request}, 0);
    check("abl_none", 48'(got_w.size() + done_cnt), 0);

    // reset in WRITE drops everything at once
    ack_mode = 5;
    env_clear();
    fifo_q = {8'hF0, 8'h0F, 8'hAB, 8'hCD};
    bank = 4'd7; address = 24'h12_3456; length = 4; start = 1'b1;
    tick();
    wait_for_request();
    reset_n = 1'b0;
    tick();
    check("rst_write", {o_busy, o_done, o_rx_read, o_mem_request, o_mem_bank, o_mem_address, o_mem_data}, 0);
    reset_n = 1'b1;
    tick();

    for (int k = 0; k < 25; k++) begin
      int len;
      logic [3:0] b;
      logic [23:0] a;
      len = $urandom_range(0, 11);
      tx_bytes.delete();
      for (int i = 0; i < len; i++) tx_bytes.push_back(8'($urandom));
      b = 4'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 24'hFF_FFFF - 24'($urandom_range(0, 3)) : 24'($urandom);
      stall_en = 1'($urandom_range(0, 1));
      ack_mode = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, 4);
      run_xfer(b, a, len, $urandom_range(0, 4) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
